demux_1to2_sched: RTL and testbench
===================================

# demux_1to2_sched

Sequencing controller for the 1-to-2 demux datapath. Accepts one valid/ready input stream and steers each accepted word to one of two registered output channels. Steering is round-robin with fallback to the free channel, or forced by an explicit select. It sits in front of two downstream consumers and replaces a free-running `sel` with a handshake-aware scheduler. It also counts the words delivered per channel.

## Interface
Parameters:
- `width`, 8, data width of input and both outputs.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `i_data`  in  width  input word.
- `i_valid`  in  1  input word present.
- `i_ready`  out  1  input word accepted this cycle when `i_valid & i_ready`.
- `force_en`  in  1  1 = steer every word to `force_sel`; 0 = round-robin.
- `force_sel`  in  1  forced target channel (0 → o0, 1 → o1).
- `o0`, `o1`  out  width  channel data, registered.
- `o0_valid`, `o1_valid`  out  1  channel holds an undelivered word.
- `o0_ready`, `o1_ready`  in  1  consumer takes the word when valid & ready.
- `cnt0`, `cnt1`  out  8  delivered-word count per channel, saturating at 255.
- `last_sel`  out  1  channel that received the most recent accepted word.

## Operation
- Each channel has a one-entry holding register: a data field plus a valid flag (`oN_valid`).
- Channel N can accept when `!oN_valid | oN_ready`. A word drained in a cycle frees that slot for an accept in the same cycle.
- Round-robin pointer `ptr` (1 bit) names the preferred channel.
- Target selection (combinational, each cycle):
  - `force_en=1`: target = `force_sel`. No fallback.
  - `force_en=0`: target = `ptr` if channel `ptr` can accept. Otherwise target = `~ptr` if channel `~ptr` can accept. Otherwise no target.
- `i_ready` = a target exists and can accept. `i_ready` does not depend on `i_valid`.
- On accept (`i_valid & i_ready`):
  - Target register loads `i_data`; its valid flag sets.
  - `last_sel` is set to the target.
  - `ptr` is set to `~target`. This applies in both modes, so round-robin resumes opposite the last forced channel.
- On drain (`oN_valid & oN_ready`) with no load into that channel: `oN_valid` clears.
- On simultaneous drain and load of the same channel: valid stays 1 and data takes the new word.
- `oN` data holds its value while valid is 0. Data is never zeroed except by reset.
- `cntN` increments by 1 on each drain of channel N and saturates at 255 (no wrap).
- The non-target channel is never written. `i_data` never appears on both outputs.

## Timing
- Reset (async assert, deassert synchronous to `clk` by integration):
  - `o0`, `o1` = 0.
  - `o0_valid`, `o1_valid` = 0.
  - `cnt0`, `cnt1` = 0.
  - `ptr` = 0, `last_sel` = 0.
  - `i_ready` is 1 after reset because both channels are empty.
- Latency: a word accepted at edge k is visible on `oN`/`oN_valid` after edge k, i.e. in cycle k+1.
- Throughput: 1 word/cycle sustained, alternating channels, when both consumers hold ready=1. In forced mode, 1 word/cycle into the forced channel while its consumer is ready.
- Backpressure: in forced mode with the forced channel full and not draining, `i_ready`=0 and the other channel is not used.
- A reset asserted mid-transfer drops any held words immediately. Counts clear, and there is no partial handshake completion.
- Changing `force_en`/`force_sel` takes effect in the same cycle's target selection. It has no effect on words already held.

## Test plan
- Reset check: hold `rst_n`=0 with arbitrary inputs → all outputs 0. After release, `i_ready`=1 and `last_sel`=0.
- Round-robin: both readys=1, `force_en`=0, stream 0xA0, 0xB0, 0xC0, 0xD0 on consecutive cycles → o0 receives 0xA0 then 0xC0, o1 receives 0xB0 then 0xD0, each one cycle after accept; final `cnt0`=2, `cnt1`=2.
- Fallback: `o0_ready`=0, `o1_ready`=1, stream 0xA0, 0xB0, 0xC0 →
  - 0xA0 goes to o0 and is held.
  - 0xB0 and 0xC0 go to o1.
  - `i_ready` stays 1 throughout.
  - `o0` stays 0xA0 with `o0_valid`=1 and `cnt0`=0.
- Forced backpressure: `force_en`=1, `force_sel`=1, `o1_ready`=0, send 0xA0 then 0xB0 →
  - 0xA0 is accepted to o1.
  - `i_ready`=0 while 0xB0 is presented, and `o0_valid` stays 0.
  - Raising `o1_ready` accepts 0xB0 in that cycle.
  - `ptr` = 0 afterwards, so the next round-robin word goes to o0.
- Saturation: drain 260 words through o0 in forced mode → `cnt0`=255 (it does not wrap to 4) and `cnt1`=0.
- Reset mid-operation: both channels valid with 0xC0/0xD0 held. Pulse `rst_n` low for half a cycle → both valids and the data clear asynchronously, counters read 0, and the next accepted word goes to o0.

Source files
------------

// File: rtl/demux_1to2_sched.sv
// Handshake-aware 1-to-2 demux: steers each accepted word into one of two
// one-entry output slots, round-robin with fallback or forced, and counts drains.
module demux_1to2_sched #(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [width-1:0] i_data,
  input  logic             i_valid,
  output logic             i_ready,
  input  logic             force_en,
  input  logic             force_sel,
  output logic [width-1:0] o0,
  output logic [width-1:0] o1,
  output logic             o0_valid,
  output logic             o1_valid,
  input  logic             o0_ready,
  input  logic             o1_ready,
  output logic [7:0]       cnt0,
  output logic [7:0]       cnt1,
  output logic             last_sel
);

  logic ptr;
  logic can0, can1;
  logic drain0, drain1;
  logic has_target, target;
  logic accept, load0, load1;

  // A slot draining this cycle is free for a same-cycle load.
  assign can0   = !o0_valid || o0_ready;
  assign can1   = !o1_valid || o1_ready;
  assign drain0 = o0_valid && o0_ready;
  assign drain1 = o1_valid && o1_ready;

  always_comb begin
    has_target = 1'b0;
    target     = ptr;
    if (force_en) begin
      target     = force_sel;
      has_target = force_sel ? can1 : can0;
    end else if (ptr ? can1 : can0) begin
      target     = ptr;
      has_target = 1'b1;
    end else if (ptr ? can0 : can1) begin
      target     = !ptr;
      has_target = 1'b1;
    end
  end

  assign i_ready = has_target;
  assign accept  = i_valid && has_target;
  assign load0   = accept && !target;
  assign load1   = accept && target;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o0       <= '0;
      o0_valid <= 1'b0;
    end else if (load0) begin
      o0       <= i_data;
      o0_valid <= 1'b1;
    end else if (drain0) begin
      o0_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o1       <= '0;
      o1_valid <= 1'b0;
    end else if (load1) begin
      o1       <= i_data;
      o1_valid <= 1'b1;
    end else if (drain1) begin
      o1_valid <= 1'b0;
    end
  end

  // Pointer moves opposite the last target in both modes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= 1'b0;
      last_sel <= 1'b0;
    end else if (accept) begin
      ptr      <= !target;
      last_sel <= target;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0 <= 8'd0;
      cnt1 <= 8'd0;
    end else begin
      if (drain0 && cnt0 != 8'hFF) cnt0 <= cnt0 + 8'd1;
      if (drain1 && cnt1 != 8'hFF) cnt1 <= cnt1 + 8'd1;
    end
  end

endmodule

// File: tb/tb_demux_1to2_sched.sv
// Self-checking bench for demux_1to2_sched: directed scenarios plus a randomized
// run checked against a slot-level reference model.
module tb_demux_1to2_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] i_data;
  logic       i_valid;
  logic       i_ready;
  logic       force_en;
  logic       force_sel;
  logic [7:0] o0, o1;
  logic       o0_valid, o1_valid;
  logic       o0_ready, o1_ready;
  logic [7:0] cnt0, cnt1;
  logic       last_sel;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: two slots, two saturating counters, a preference bit.
  logic [7:0] m_data [2];
  logic       m_valid[2];
  int         m_cnt  [2];
  logic       m_ptr;
  logic       m_last;

  demux_1to2_sched #(.width(8)) dut (
    .clk(clk), .rst_n(rst_n), .i_data(i_data), .i_valid(i_valid), .i_ready(i_ready),
    .force_en(force_en), .force_sel(force_sel), .o0(o0), .o1(o1),
    .o0_valid(o0_valid), .o1_valid(o1_valid), .o0_ready(o0_ready), .o1_ready(o1_ready),
    .cnt0(cnt0), .cnt1(cnt1), .last_sel(last_sel)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int n = 0; n < 2; n++) begin
      m_data[n] = 8'h00; m_valid[n] = 1'b0; m_cnt[n] = 0;
    end
    m_ptr = 1'b0; m_last = 1'b0;
  endtask

  function automatic logic [1:0] model_pick();
    logic free [2];
    free[0] = !m_valid[0] || o0_ready;
    free[1] = !m_valid[1] || o1_ready;
    if (force_en)      return {free[force_sel], force_sel};
    if (free[m_ptr])   return {1'b1, m_ptr};
    if (free[!m_ptr])  return {1'b1, !m_ptr};
    return 2'b00;
  endfunction

  task automatic model_edge();
    logic [1:0] pick;
    logic       rdy[2];
    pick = model_pick();
    rdy[0] = o0_ready; rdy[1] = o1_ready;
    for (int n = 0; n < 2; n++) begin
      if (m_valid[n] && rdy[n] && m_cnt[n] < 255) m_cnt[n]++;
      if (i_valid && pick[1] && pick[0] == n[0]) begin
        m_data[n] = i_data; m_valid[n] = 1'b1;
      end else if (m_valid[n] && rdy[n]) begin
        m_valid[n] = 1'b0;
      end
    end
    if (i_valid && pick[1]) begin
      m_last = pick[0]; m_ptr = !pick[0];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    i_data = 8'h00; i_valid = 1'b0; force_en = 1'b0; force_sel = 1'b0;
    o0_ready = 1'b0; o1_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    tick(); tick();
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    i_data = 8'h5A; i_valid = 1'b1; force_en = 1'b1; force_sel = 1'b1;
    o0_ready = 1'b1; o1_ready = 1'b0;
    model_reset();
    @(posedge clk); #1; @(posedge clk); #1;
    n_checks++;
    if ({o0, o1, o0_valid, o1_valid, cnt0, cnt1, last_sel} !== 35'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: got o0=%h o1=%h v=%b%b c0=%0d c1=%0d last=%b, want all 0",
               o0, o1, o0_valid, o1_valid, cnt0, cnt1, last_sel);
    end
    rst_n = 1'b1;
    idle_inputs();
    #1;
    n_checks++;
    if (i_ready !== 1'b1 || last_sel !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_release: got i_ready=%b last_sel=%b, want 1 0", i_ready, last_sel);
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] words[4] = '{8'hA0, 8'hB0, 8'hC0, 8'hD0};
    do_reset();
    o0_ready = 1'b1; o1_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      i_data = words[k]; i_valid = 1'b1;
      tick();
      n_checks++;
      if (k % 2 == 0) begin
        if (o0 !== words[k] || o0_valid !== 1'b1 || o1_valid !== 1'b0 || last_sel !== 1'b0) begin
          n_fail++;
          $display("[TB] FAIL rr_word%0d: got o0=%h v0=%b v1=%b last=%b, want o0=%h v0=1 v1=0 last=0",
                   k, o0, o0_valid, o1_valid, last_sel, words[k]);
        end
      end else begin
        if (o1 !== words[k] || o1_valid !== 1'b1 || o0_valid !== 1'b0 || last_sel !== 1'b1) begin
          n_fail++;
          $display("[TB] FAIL rr_word%0d: got o1=%h v1=%b v0=%b last=%b, want o1=%h v1=1 v0=0 last=1",
                   k, o1, o1_valid, o0_valid, last_sel, words[k]);
        end
      end
    end
    i_valid = 1'b0;
    tick();
    n_checks++;
    if (cnt0 !== 8'd2 || cnt1 !== 8'd2) begin
      n_fail++;
      $display("[TB] FAIL rr_counts: got cnt0=%0d cnt1=%0d, want 2 2", cnt0, cnt1);
    end
  endtask

  task automatic test_fallback();
    logic [7:0] words[3] = '{8'hA0, 8'hB0, 8'hC0};
    logic       rdy_ok = 1'b1;
    do_reset();
    o0_ready = 1'b0; o1_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      i_data = words[k]; i_valid = 1'b1;
      #1;
      if (i_ready !== 1'b1) rdy_ok = 1'b0;
      tick();
    end
    i_valid = 1'b0;
    n_checks++;
    if (!rdy_ok) begin
      n_fail++;
      $display("[TB] FAIL fallback_ready: got i_ready low during stream, want 1 throughout");
    end
    n_checks++;
    if (o0 !== 8'hA0 || o0_valid !== 1'b1 || cnt0 !== 8'd0) begin
      n_fail++;
      $display("[TB] FAIL fallback_hold: got o0=%h v0=%b cnt0=%0d, want A0 1 0", o0, o0_valid, cnt0);
    end
    n_checks++;
    if (o1 !== 8'hC0 || o1_valid !== 1'b1 || cnt1 !== 8'd1 || last_sel !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL fallback_o1: got o1=%h v1=%b cnt1=%0d last=%b, want C0 1 1 1",
               o1, o1_valid, cnt1, last_sel);
    end
  endtask

  task automatic test_forced_backpressure();
    do_reset();
    force_en = 1'b1; force_sel = 1'b1; o0_ready = 1'b1; o1_ready = 1'b0;
    i_data = 8'hA0; i_valid = 1'b1;
    tick();
    i_data = 8'hB0;
    #1;
    n_checks++;
    if (i_ready !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL forced_stall: got i_ready=%b, want 0", i_ready);
    end
    tick();
    n_checks++;
    if (o0_valid !== 1'b0 || o1 !== 8'hA0 || o1_valid !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL forced_no_spill: got v0=%b o1=%h v1=%b, want 0 A0 1", o0_valid, o1, o1_valid);
    end
    o1_ready = 1'b1;
    #1;
    n_checks++;
    if (i_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL forced_release: got i_ready=%b, want 1", i_ready);
    end
    tick();
    n_checks++;
    if (o1 !== 8'hB0 || o1_valid !== 1'b1 || cnt1 !== 8'd1) begin
      n_fail++;
      $display("[TB] FAIL forced_accept: got o1=%h v1=%b cnt1=%0d, want B0 1 1", o1, o1_valid, cnt1);
    end
    force_en = 1'b0; i_data = 8'hE0;
    tick();
    i_valid = 1'b0;
    n_checks++;
    if (o0 !== 8'hE0 || o0_valid !== 1'b1 || last_sel !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL forced_resume: got o0=%h v0=%b last=%b, want E0 1 0", o0, o0_valid, last_sel);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    force_en = 1'b1; force_sel = 1'b0; o0_ready = 1'b1; o1_ready = 1'b1;
    i_valid = 1'b1;
    for (int k = 0; k < 260; k++) begin
      i_data = k[7:0];
      tick();
    end
    i_valid = 1'b0;
    tick();
    n_checks++;
    if (cnt0 !== 8'd255 || cnt1 !== 8'd0) begin
      n_fail++;
      $display("[TB] FAIL saturation: got cnt0=%0d cnt1=%0d, want 255 0", cnt0, cnt1);
    end
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    i_valid = 1'b1; i_data = 8'hC0;
    tick();
    i_data = 8'hD0;
    tick();
    i_valid = 1'b0;
    n_checks++;
    if (o0 !== 8'hC0 || o1 !== 8'hD0 || o0_valid !== 1'b1 || o1_valid !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL midrst_setup: got o0=%h o1=%h v=%b%b, want C0 D0 11", o0, o1, o0_valid, o1_valid);
    end
    rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if ({o0, o1, o0_valid, o1_valid, cnt0, cnt1} !== 34'd0) begin
      n_fail++;
      $display("[TB] FAIL midrst_clear: got o0=%h o1=%h v=%b%b c0=%0d c1=%0d, want all 0",
               o0, o1, o0_valid, o1_valid, cnt0, cnt1);
    end
    #4;
    rst_n = 1'b1;
    o0_ready = 1'b1; o1_ready = 1'b1; i_data = 8'hF0; i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    n_checks++;
    if (o0 !== 8'hF0 || o0_valid !== 1'b1 || o1_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL midrst_next: got o0=%h v0=%b v1=%b, want F0 1 0", o0, o0_valid, o1_valid);
    end
  endtask

  task automatic test_random();
    logic [1:0] pick;
    do_reset();
    for (int k = 0; k < 400; k++) begin
      i_data    = 8'($urandom);
      i_valid   = ($urandom_range(0, 3) != 0);
      force_en  = ($urandom_range(0, 3) == 0);
      force_sel = 1'($urandom);
      o0_ready  = ($urandom_range(0, 2) != 0);
      o1_ready  = ($urandom_range(0, 2) != 0);
      #1;
      pick = model_pick();
      n_checks++;
      if (i_ready !== pick[1]) begin
        n_fail++;
        $display("[TB] FAIL rand_ready[%0d]: got i_ready=%b, want %b", k, i_ready, pick[1]);
      end
      tick();
      n_checks++;
      if (o0 !== m_data[0] || o1 !== m_data[1] || o0_valid !== m_valid[0] || o1_valid !== m_valid[1]
          || cnt0 !== 8'(m_cnt[0]) || cnt1 !== 8'(m_cnt[1]) || last_sel !== m_last) begin
        n_fail++;
        $display("[TB] FAIL rand_state[%0d]: got o0=%h o1=%h v=%b%b c=%0d/%0d last=%b, want o0=%h o1=%h v=%b%b c=%0d/%0d last=%b",
                 k, o0, o1, o0_valid, o1_valid, cnt0, cnt1, last_sel,
                 m_data[0], m_data[1], m_valid[0], m_valid[1], m_cnt[0], m_cnt[1], m_last);
      end
    end
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    #1;
    test_reset();
    test_round_robin();
    test_fallback();
    test_forced_backpressure();
    test_saturation();
    test_reset_mid_op();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
